// File: rtl/alu_operand_collector.sv
// Operand collector in front of the warp ALU. It fetches up to three source operands
// serially through a one-port register file and hands the bundle over with valid/ready.
package warp_pkg;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_MUL  = 3'd1,
        OP_MAX  = 3'd2,
        OP_RELU = 3'd3,
        OP_FMA  = 3'd4
    } alu_opcode_e;
endpackage

module alu_operand_collector #(
    parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  warp_pkg::alu_opcode_e  in_opcode,
    input  logic [REG_ADDR_W-1:0]  in_rs1,
    input  logic [REG_ADDR_W-1:0]  in_rs2,
    input  logic [REG_ADDR_W-1:0]  in_rs3,
    input  logic [REG_ADDR_W-1:0]  in_rd,
    output logic                   rf_rd_en,
    output logic [REG_ADDR_W-1:0]  rf_rd_addr,
    input  logic [DATA_WIDTH-1:0]  rf_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output warp_pkg::alu_opcode_e  out_opcode,
    output logic [DATA_WIDTH-1:0]  out_op1,
    output logic [DATA_WIDTH-1:0]  out_op2,
    output logic [DATA_WIDTH-1:0]  out_op3,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic                   busy
);
    // state | meaning
    // IDLE  | no instruction held, ready for a new one
    // FETCH | register reads in flight, operands being captured
    // ISSUE | bundle complete, out_valid high until the ALU takes it
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_e;

    state_e                 state, state_nxt;
    logic                   accept;
    logic                   last_cap;
    logic [1:0]             in_n;
    logic [1:0]             n_q;
    logic [1:0]             rd_idx;
    logic [1:0]             cap_idx;
    logic                   cap_en;
    logic [REG_ADDR_W-1:0]  rs2_q, rs3_q;

    function automatic logic [1:0] op_count(input warp_pkg::alu_opcode_e op);
        case (op)
            warp_pkg::OP_RELU:                                    return 2'd1;
            warp_pkg::OP_ADD, warp_pkg::OP_MUL, warp_pkg::OP_MAX: return 2'd2;
            warp_pkg::OP_FMA:                                     return 2'd3;
            default:                                              return 2'd0;
        endcase
    endfunction

    assign in_n     = op_count(in_opcode);
    assign accept   = in_valid && in_ready;
    assign last_cap = (state == FETCH) && cap_en && (cap_idx == n_q - 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = (in_n == 2'd0) ? ISSUE : FETCH;
            FETCH: if (last_cap) state_nxt = ISSUE;
            ISSUE: begin
                if (out_ready) begin
                    if (accept) state_nxt = (in_n == 2'd0) ? ISSUE : FETCH;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) || ((state == ISSUE) && out_ready);
        busy     = (state != IDLE);
    end

    // The first read is launched straight from the acceptance edge, so rs1 is never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_rd_en   <= 1'b0;
            rf_rd_addr <= '0;
            out_valid  <= 1'b0;
            out_opcode <= warp_pkg::OP_ADD;
            out_op1    <= '0;
            out_op2    <= '0;
            out_op3    <= '0;
            out_rd     <= '0;
            n_q        <= '0;
            rd_idx     <= '0;
            cap_idx    <= '0;
            cap_en     <= 1'b0;
            rs2_q      <= '0;
            rs3_q      <= '0;
        end else begin
            cap_en <= rf_rd_en;
            if (accept) begin
                out_opcode <= in_opcode;
                out_rd     <= in_rd;
                out_op1    <= '0;
                out_op2    <= '0;
                out_op3    <= '0;
                n_q        <= in_n;
                rs2_q      <= in_rs2;
                rs3_q      <= in_rs3;
                cap_idx    <= '0;
                rd_idx     <= 2'd1;
                if (in_n != 2'd0) begin
                    rf_rd_en   <= 1'b1;
                    rf_rd_addr <= in_rs1;
                    out_valid  <= 1'b0;
                end else begin
                    rf_rd_en   <= 1'b0;
                    rf_rd_addr <= '0;
                    out_valid  <= 1'b1;
                end
            end else begin
                if ((state == FETCH) && (rd_idx < n_q)) begin
                    rf_rd_en   <= 1'b1;
                    rf_rd_addr <= (rd_idx == 2'd1) ? rs2_q : rs3_q;
                    rd_idx     <= rd_idx + 2'd1;
                end else begin
                    rf_rd_en   <= 1'b0;
                    rf_rd_addr <= '0;
                end
                if ((state == FETCH) && cap_en) begin
                    case (cap_idx)
                        2'd0:    out_op1 <= rf_rd_data;
                        2'd1:    out_op2 <= rf_rd_data;
                        default: out_op3 <= rf_rd_data;
                    endcase
                    cap_idx <= cap_idx + 2'd1;
                    if (last_cap) out_valid <= 1'b1;
                end
                if ((state == ISSUE) && out_ready) out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_collector.sv
// Bench for alu_operand_collector: directed scenarios with literal expectations,
// then random traffic checked every cycle against a timeline model of each instruction.
module tb_alu_operand_collector;
    import warp_pkg::*;

    localparam int DW = warp_pkg::DATA_WIDTH;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    alu_opcode_e    in_opcode = OP_ADD;
    logic [AW-1:0]  in_rs1 = '0, in_rs2 = '0, in_rs3 = '0, in_rd = '0;
    logic           rf_rd_en;
    logic [AW-1:0]  rf_rd_addr;
    logic [DW-1:0]  rf_rd_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    alu_opcode_e    out_opcode;
    logic [DW-1:0]  out_op1, out_op2, out_op3;
    logic [AW-1:0]  out_rd;
    logic           busy;

    always #5 clk = ~clk;

    alu_operand_collector #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_rd(in_rd),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3),
        .out_rd(out_rd), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [DW-1:0] rf_mem [32];
    logic          prev_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // Model: one held instruction, described by its acceptance cycle and operand list.
    bit            have_txn = 1'b0;
    int            t0 = 0;
    int            m_n = 0;
    logic [AW-1:0] m_rs [3];
    logic [AW-1:0] m_rd;
    alu_opcode_e   m_op;
    logic [DW-1:0] m_ops [3];

    function automatic int n_of(input alu_opcode_e op);
        case (op)
            OP_RELU:               return 1;
            OP_ADD, OP_MUL, OP_MAX: return 2;
            OP_FMA:                return 3;
            default:               return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic step(input bit v, input alu_opcode_e op, input int r1, input int r2,
                        input int r3, input int rd, input bit ordy);
        bit            ev, een, acc, cons;
        logic [AW-1:0] ea;
        int            lat, k;
        @(negedge clk);
        rf_rd_data = prev_en ? rf_mem[prev_addr] : DW'($urandom);
        prev_en    = rf_rd_en;
        prev_addr  = rf_rd_addr;
        in_valid   = v;
        in_opcode  = op;
        in_rs1     = AW'(r1);
        in_rs2     = AW'(r2);
        in_rs3     = AW'(r3);
        in_rd      = AW'(rd);
        out_ready  = ordy;
        #1;
        lat = (m_n == 0) ? 1 : m_n + 2;
        ev  = have_txn && (cyc >= t0 + lat);
        k   = cyc - t0 - 1;
        een = have_txn && (k >= 0) && (k < m_n);
        ea  = '0;
        if (een) ea = m_rs[k];
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("rf_rd_en", 64'(rf_rd_en), 64'(een));
        chk("rf_rd_addr", 64'(rf_rd_addr), 64'(ea));
        chk("busy", 64'(busy), 64'(have_txn));
        chk("in_ready", 64'(in_ready), 64'(!have_txn || (ev && ordy)));
        if (ev) begin
            chk("out_opcode", 64'(out_opcode), 64'(m_op));
            chk("out_op1", 64'(out_op1), 64'(m_ops[0]));
            chk("out_op2", 64'(out_op2), 64'(m_ops[1]));
            chk("out_op3", 64'(out_op3), 64'(m_ops[2]));
            chk("out_rd", 64'(out_rd), 64'(m_rd));
        end
        cons = ev && ordy;
        acc  = v && (!have_txn || cons);
        if (cons) have_txn = 1'b0;
        if (acc) begin
            have_txn = 1'b1;
            t0       = cyc;
            m_n      = n_of(op);
            m_op     = op;
            m_rd     = AW'(rd);
            m_rs[0]  = AW'(r1);
            m_rs[1]  = AW'(r2);
            m_rs[2]  = AW'(r3);
            for (int i = 0; i < 3; i++) m_ops[i] = (i < m_n) ? rf_mem[m_rs[i]] : '0;
        end
        cyc++;
    endtask

    // Idle cycle with in_* scrambled: the collector must ignore them.
    task automatic idle(input bit ordy);
        step(1'b0, alu_opcode_e'(3'($urandom_range(0, 7))), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), ordy);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = DW'($urandom);
        rf_mem[1] = 32'd5;
        rf_mem[2] = 32'd7;
        rf_mem[3] = 32'd100;
        rf_mem[4] = 32'hFFFF_FFFF;

        idle(1'b1);
        idle(1'b1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset rf_rd_en", 64'(rf_rd_en), 64'd0);
        chk("reset rf_rd_addr", 64'(rf_rd_addr), 64'd0);
        chk("reset out_ops", {out_op1, out_op2} | 64'(out_op3), 64'd0);
        chk("reset out_rd", 64'(out_rd), 64'd0);
        chk("reset out_opcode", 64'(out_opcode), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle(1'b1);

        // ADD r1+r2 -> reads at cycles 1,2, bundle at cycle 4
        step(1'b1, OP_ADD, 1, 2, 0, 9, 1'b1);
        idle(1'b1); chk("add rd addr c1", 64'(rf_rd_addr), 64'd1);
        idle(1'b1); chk("add rd addr c2", 64'(rf_rd_addr), 64'd2);
        idle(1'b1); chk("add valid c3", 64'(out_valid), 64'd0);
        idle(1'b1);
        chk("add valid c4", 64'(out_valid), 64'd1);
        chk("add op1", 64'(out_op1), 64'd5);
        chk("add op2", 64'(out_op2), 64'd7);
        chk("add op3", 64'(out_op3), 64'd0);
        chk("add rd", 64'(out_rd), 64'd9);
        idle(1'b1); chk("add valid drop", 64'(out_valid), 64'd0);

        // FMA r1*r2+r3
        step(1'b1, OP_FMA, 1, 2, 3, 11, 1'b1);
        idle(1'b1); chk("fma addr c1", 64'(rf_rd_addr), 64'd1);
        idle(1'b1); chk("fma addr c2", 64'(rf_rd_addr), 64'd2);
        idle(1'b1); chk("fma addr c3", 64'(rf_rd_addr), 64'd3);
        idle(1'b1); chk("fma no 4th read", 64'(rf_rd_en), 64'd0);
        idle(1'b1);
        chk("fma valid c5", 64'(out_valid), 64'd1);
        chk("fma result", 64'(out_op1) * 64'(out_op2) + 64'(out_op3), 64'd135);

        // RELU r4
        step(1'b1, OP_RELU, 4, 2, 3, 1, 1'b1);
        idle(1'b1); chk("relu addr c1", 64'(rf_rd_addr), 64'd4);
        idle(1'b1); chk("relu no 2nd read", 64'(rf_rd_en), 64'd0);
        idle(1'b1);
        chk("relu valid c3", 64'(out_valid), 64'd1);
        chk("relu op1", 64'(out_op1), 64'hFFFF_FFFF);
        chk("relu op2", 64'(out_op2), 64'd0);

        // Unknown opcode: no reads, bundle the next cycle
        step(1'b1, alu_opcode_e'(3'd6), 1, 2, 3, 5, 1'b1);
        idle(1'b1);
        chk("unk valid c1", 64'(out_valid), 64'd1);
        chk("unk rd_en", 64'(rf_rd_en), 64'd0);
        chk("unk ops", {out_op1, out_op2} | 64'(out_op3), 64'd0);

        // Backpressure with a second ADD waiting on in_valid
        step(1'b1, OP_ADD, 1, 2, 0, 3, 1'b1);
        idle(1'b0); idle(1'b0); idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, OP_ADD, 3, 4, 0, 7, 1'b0);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp op1 held", 64'(out_op1), 64'd5);
        end
        step(1'b1, OP_ADD, 3, 4, 0, 7, 1'b1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        idle(1'b1);
        chk("bp2 valid", 64'(out_valid), 64'd1);
        chk("bp2 op1", 64'(out_op1), 64'd100);
        chk("bp2 op2", 64'(out_op2), 64'hFFFF_FFFF);

        // Reset in cycle 2 of an FMA
        step(1'b1, OP_FMA, 1, 2, 3, 4, 1'b1);
        idle(1'b1);
        idle(1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid-reset rf_rd_en", 64'(rf_rd_en), 64'd0);
        chk("mid-reset busy", 64'(busy), 64'd0);
        chk("mid-reset out_valid", 64'(out_valid), 64'd0);
        have_txn = 1'b0;
        prev_en  = 1'b0;
        idle(1'b1);
        idle(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle(1'b1);
        step(1'b1, OP_ADD, 2, 1, 0, 8, 1'b1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        idle(1'b1);
        chk("post-reset add valid", 64'(out_valid), 64'd1);
        chk("post-reset add op1", 64'(out_op1), 64'd7);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), alu_opcode_e'(3'($urandom_range(0, 7))),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Upstream neighbour of the warp ALU.
- Accepts one decoded ALU instruction at a time: opcode, up to three source register indices and a destination tag.
- Fetches the needed operands serially through a single-read-port register file (1-cycle read latency).
- Presents opcode, operand1/2/3 and destination to the ALU over a valid/ready handshake; the ALU side consumes in the same cycle.

Parameters:
- DATA_WIDTH, warp_pkg::DATA_WIDTH, operand width; matches the ALU.
- REG_ADDR_W, 5, register index width (32 registers).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction offered
- in_ready  output  1  collector can accept an instruction
- in_opcode  input  warp_pkg::alu_opcode_e  ALU operation
- in_rs1, in_rs2, in_rs3  input  REG_ADDR_W each  source register indices
- in_rd  input  REG_ADDR_W  destination index, passed through unchanged
- rf_rd_en  output  1  register file read strobe
- rf_rd_addr  output  REG_ADDR_W  read address
- rf_rd_data  input  DATA_WIDTH  read data, valid the cycle after rf_rd_en
- out_valid  output  1  operand bundle valid to ALU
- out_ready  input  1  ALU consumes bundle
- out_opcode  output  warp_pkg::alu_opcode_e  registered opcode
- out_op1, out_op2, out_op3  output  DATA_WIDTH each  operands
- out_rd  output  REG_ADDR_W  registered destination
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - out_valid=0, rf_rd_en=0, rf_rd_addr=0, out_op1/2/3=0, out_rd=0, out_opcode=OP_ADD (encoding 0), busy=0.
  - An in-flight instruction is discarded and never appears on out_*.
- Operand count N from opcode:
  - OP_RELU=1 (rs1)
  - OP_ADD, OP_MUL, OP_MAX=2 (rs1, rs2)
  - OP_FMA=3 (rs1, rs2, rs3)
  - any other encoding=0
- Unused operand slots are driven to 0 (never stale data).
- States: IDLE, FETCH, ISSUE.
- in_ready = (state==IDLE) || (state==ISSUE && out_ready). Acceptance happens on in_valid && in_ready at a rising edge.
- Timing, with cycle 0 = acceptance cycle:
  - Cycles 1..N: rf_rd_en=1, rf_rd_addr = rs1, rs2, rs3 in order. Reads are back-to-back with no bubbles.
  - rf_rd_data in cycle i+1 is captured into operand slot i at the end of that cycle.
  - out_valid rises in cycle N+2 (RELU 3, ADD/MUL/MAX 4, FMA 5).
  - For N=0, out_valid rises in cycle 1 with all operands 0 and no RF reads.
- When rf_rd_en=0, rf_rd_addr=0.
- Exactly N reads per instruction; the registered index is not reused.
- FETCH → ISSUE once the last operand is captured.
- ISSUE:
  - out_valid held high.
  - All out_* held stable while out_valid && !out_ready.
  - On out_ready: if a new instruction is accepted in the same cycle, go to FETCH (or ISSUE when N=0) with the new payload; otherwise go to IDLE and drop out_valid the next cycle.
- in_* are sampled only at acceptance. Changes to in_* during FETCH/ISSUE have no effect.
- rf_rd_data is ignored in cycles not following rf_rd_en.
- No combinational path from rf_rd_data to out_*. All outputs are registered except in_ready.

Test Plan:
- Preload RF r1=5, r2=7, r3=100, r4=0xFFFFFFFF.
  - OP_ADD rs1=1 rs2=2 rd=9 accepted cycle 0 → rf_rd_addr 1 (cycle 1), 2 (cycle 2); out_valid cycle 4 with op1=5, op2=7, op3=0, rd=9.
- OP_FMA rs1=1 rs2=2 rs3=3 → exactly 3 reads (addrs 1,2,3, cycles 1-3); out_valid cycle 5 with op1=5, op2=7, op3=100. ALU result must be 135.
- OP_RELU rs1=4 → single read of addr 4; out_valid cycle 3 with op1=0xFFFFFFFF, op2=op3=0. Unknown opcode → no rf_rd_en, out_valid cycle 1, all operands 0.
- Backpressure: hold out_ready=0 for 3 cycles during ADD bundle → out_* unchanged, in_ready=0. Second ADD (r3+r4) held on in_valid is accepted in the cycle out_ready=1. Its out_valid appears 4 cycles later with op1=100, op2=0xFFFFFFFF.
- Reset mid-FETCH: pull rst_n low in cycle 2 of an FMA → out_valid, rf_rd_en, busy go 0 immediately. After release no bundle is emitted, and a following ADD completes with correct timing.
- Garbage on rf_rd_data while rf_rd_en was 0, and in_rs* changing during FETCH → captured operands unaffected.
